// File: rtl/reg_dump_reader.sv
`default_nettype none
// ============================================================================
//  Module   : reg_dump_reader
//  Purpose  : Walks every architectural register through the register file's
//             combinational read port, snapshots each value and streams it
//             out MSB-first as bytes on a valid/ready interface, preceded by
//             a single SYNC_BYTE frame header.
//  Ports    : CLK       - system clock, rising edge
//             RST       - synchronous active-high reset
//             start     - single-cycle dump request (ignored while busy)
//             rd_addr   - register index to the register file read port
//             rd_val    - register file read data for rd_addr (same cycle)
//             out_data  - stream byte
//             out_valid - out_data holds a valid byte
//             out_ready - downstream accepts the byte
//             busy      - dump in progress (non-IDLE)
//             done      - one-cycle pulse after the final byte transfers
//  Revision : 1.0 - initial release
// ============================================================================
module reg_dump_reader #(
  parameter int         REG_WIDTH      = 16,
  parameter int         NUM_REGS       = 8,
  parameter int         NUM_REGS_WIDTH = 3,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      start,
  output logic [NUM_REGS_WIDTH-1:0] rd_addr,
  input  logic [REG_WIDTH-1:0]      rd_val,
  output logic [7:0]                out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      busy,
  output logic                      done
);

  localparam int BYTES  = REG_WIDTH / 8;
  localparam int BCNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  localparam logic [BCNT_W-1:0]         C_LAST_BYTE = BCNT_W'(BYTES - 1);
  localparam logic [NUM_REGS_WIDTH-1:0] C_LAST_REG  = NUM_REGS_WIDTH'(NUM_REGS - 1);
  localparam logic [NUM_REGS_WIDTH-1:0] C_IDX_ONE   = NUM_REGS_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SYNC  = 3'd1,
    S_FETCH = 3'd2,
    S_SEND  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                    state_q, state_d;
  logic [NUM_REGS_WIDTH-1:0] index_q, index_d;
  logic [BCNT_W-1:0]         bcnt_q,  bcnt_d;
  logic [REG_WIDTH-1:0]      snap_q,  snap_d;

  // The index register doubles as the read address: it only changes on the
  // transfer that leads into FETCH, so it naturally holds its last value
  // everywhere else and is 0 after reset.
  assign rd_addr = index_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      index_q <= '0;
      bcnt_q  <= '0;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      bcnt_q  <= bcnt_d;
      snap_q  <= snap_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    index_d   = index_q;
    bcnt_d    = bcnt_q;
    snap_d    = snap_q;
    out_valid = 1'b0;
    out_data  = 8'h00;
    busy      = (state_q != S_IDLE);
    done      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SYNC;
        end
      end

      S_SYNC: begin
        out_valid = 1'b1;
        out_data  = SYNC_BYTE;
        if (out_ready) begin
          index_d = '0;
          state_d = S_FETCH;
        end
      end

      S_FETCH: begin
        // Snapshot taken here; later writes to this register are not seen.
        snap_d  = rd_val;
        bcnt_d  = '0;
        state_d = S_SEND;
      end

      S_SEND: begin
        out_valid = 1'b1;
        out_data  = snap_q[REG_WIDTH-1 -: 8];
        if (out_ready) begin
          snap_d = snap_q << 8;
          bcnt_d = bcnt_q + BCNT_W'(1);
          if (bcnt_q == C_LAST_BYTE) begin
            if (index_q == C_LAST_REG) begin
              state_d = S_DONE;
            end else begin
              index_d = index_q + C_IDX_ONE;
              state_d = S_FETCH;
            end
          end
        end
      end

      S_DONE: begin
        // start is deliberately not looked at here.
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_dump_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reg_dump_reader
//  Purpose  : Directed self-checking bench for reg_dump_reader. A small
//             register file model feeds rd_val; a negedge monitor records
//             every transferred byte and every done cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_reg_dump_reader;

  logic        CLK = 1'b0;
  logic        RST;
  logic        start;
  logic [2:0]  rd_addr;
  logic [15:0] rd_val;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;

  always #5 CLK = ~CLK;

  reg_dump_reader #(
    .REG_WIDTH      (16),
    .NUM_REGS       (8),
    .NUM_REGS_WIDTH (3),
    .SYNC_BYTE      (8'hA5)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .start     (start),
    .rd_addr   (rd_addr),
    .rd_val    (rd_val),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  logic [15:0] regs [8];
  assign rd_val = regs[rd_addr];

  int errors = 0;
  int checks = 0;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  logic [7:0] bytes [$];
  int done_cnt = 0;
  int done_cyc = 0;

  always @(negedge CLK) begin
    if (RST !== 1'b1) begin
      if (out_valid === 1'b1 && out_ready === 1'b1) bytes.push_back(out_data);
      if (done === 1'b1) begin
        done_cnt = done_cnt + 1;
        done_cyc = cyc;
      end
    end
  end

  logic [7:0] exp_a [17] = '{8'hA5, 8'h00, 8'h00, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01,
                             8'h80, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'hFF, 8'h5A, 8'h5A};
  logic [7:0] exp_b [17] = '{8'hA5, 8'h00, 8'h00, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01,
                             8'h80, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'hFF, 8'h77, 8'h77};

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns in the DONE cycle (done visible), or after the budget expires.
  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(done), 32'd1);
  endtask

  task automatic check_stream(input string tag, input int base, input bit use_b);
    logic [7:0] got;
    logic [7:0] want;
    check({tag, "_len"}, 32'(bytes.size() - base), 32'd17);
    for (int i = 0; i < 17; i++) begin
      got  = (base + i < bytes.size()) ? bytes[base + i] : 8'hxx;
      want = use_b ? exp_b[i] : exp_a[i];
      check($sformatf("%s_b%0d", tag, i), 32'(got), 32'(want));
    end
  endtask

  task automatic start_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int base;
    int dc0;
    int sync_cyc;
    int n;

    regs[0] = 16'h0000; regs[1] = 16'h1234; regs[2] = 16'hABCD; regs[3] = 16'h0001;
    regs[4] = 16'h8000; regs[5] = 16'hFFFF; regs[6] = 16'h00FF; regs[7] = 16'h5A5A;
    RST = 1'b1; start = 1'b0; out_ready = 1'b1;

    // ---- reset then idle ----
    tick(); tick();
    RST = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_valid", 32'(out_valid), 32'd0);
      check("idle_busy",  32'(busy),      32'd0);
      check("idle_done",  32'(done),      32'd0);
      check("idle_addr",  32'(rd_addr),   32'd0);
    end
    check("idle_data", 32'(out_data), 32'd0);

    // ---- full dump, ready held high ----
    base = bytes.size(); dc0 = done_cnt;
    start_frame();
    sync_cyc = cyc;
    check("sync_busy",  32'(busy),      32'd1);
    check("sync_valid", 32'(out_valid), 32'd1);
    check("sync_data",  32'(out_data),  32'hA5);
    wait_done("full_done_timeout", 100);
    check("full_latency", 32'(cyc - sync_cyc), 32'd25);
    check("full_busy_in_done", 32'(busy), 32'd1);
    tick();
    check("full_busy_after", 32'(busy), 32'd0);
    check("full_done_after", 32'(done), 32'd0);
    check("full_done_count", 32'(done_cnt - dc0), 32'd1);
    check("full_done_cyc", 32'(done_cyc - sync_cyc), 32'd25);
    check_stream("full", base, 1'b0);

    // ---- backpressure on byte 12 ----
    base = bytes.size(); dc0 = done_cnt;
    start_frame();
    n = 0;
    while (!(out_valid === 1'b1 && out_data === 8'h12) && n < 20) begin
      tick();
      n++;
    end
    out_ready = 1'b0;
    check("bp_found", 32'(out_data), 32'h12);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_data",  32'(out_data),  32'h12);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    wait_done("bp_done_timeout", 100);
    tick();
    check("bp_done_count", 32'(done_cnt - dc0), 32'd1);
    check_stream("bp", base, 1'b0);

    // ---- snapshot timing ----
    base = bytes.size(); dc0 = done_cnt;
    start_frame();
    n = 0;
    while (!(busy === 1'b1 && out_valid === 1'b0 && done === 1'b0 && rd_addr === 3'd1) && n < 20) begin
      tick();
      n++;
    end
    check("snap_fetch1_addr", 32'(rd_addr), 32'd1);
    tick();
    regs[1] = 16'h9999;
    regs[7] = 16'h7777;
    wait_done("snap_done_timeout", 100);
    check("snap_addr_hold", 32'(rd_addr), 32'd7);
    tick();
    check("snap_addr_idle", 32'(rd_addr), 32'd7);
    check("snap_done_count", 32'(done_cnt - dc0), 32'd1);
    check_stream("snap", base, 1'b1);
    regs[1] = 16'h1234;
    regs[7] = 16'h5A5A;

    // ---- start ignored in SYNC, SEND and DONE ----
    base = bytes.size(); dc0 = done_cnt;
    start = 1'b1;
    tick();                 // now SYNC, start still high across SYNC
    check("ign_sync_state", 32'(out_data), 32'hA5);
    tick();                 // FETCH
    start = 1'b0;
    tick();                 // SEND
    check("ign_send_valid", 32'(out_valid), 32'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("ign_done_timeout", 100);
    start = 1'b1;           // sampled at the DONE edge, must be ignored
    tick();
    check("ign_busy_after_done", 32'(busy), 32'd0);
    check("ign_valid_after_done", 32'(out_valid), 32'd0);
    check("ign_done_count", 32'(done_cnt - dc0), 32'd1);
    check_stream("ign", base, 1'b0);

    // ---- start in the cycle after DONE is accepted; then reset mid-frame ----
    base = bytes.size(); dc0 = done_cnt;
    tick();                 // start still high, sampled in IDLE
    start = 1'b0;
    check("accept_busy", 32'(busy), 32'd1);
    check("accept_sync", 32'(out_data), 32'hA5);
    n = 0;
    while (bytes.size() - base < 6 && n < 40) begin
      tick();
      n++;
    end
    check("rst_six_bytes", 32'(bytes.size() - base), 32'd6);
    RST = 1'b1;
    tick();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_busy",  32'(busy),      32'd0);
    check("rst_done",  32'(done),      32'd0);
    check("rst_addr",  32'(rd_addr),   32'd0);
    check("rst_data",  32'(out_data),  32'd0);
    RST = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("rst_no_done", 32'(done_cnt - dc0), 32'd0);
    check("rst_no_bytes", 32'(bytes.size() - base), 32'd6);
    check("rst_idle_busy", 32'(busy), 32'd0);

    base = bytes.size(); dc0 = done_cnt;
    start_frame();
    wait_done("post_rst_done_timeout", 100);
    tick();
    check("post_rst_done_count", 32'(done_cnt - dc0), 32'd1);
    check_stream("post_rst", base, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
